// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with loadable pattern, overlap control and saturating match counter.
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1001,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(PAT_W+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_count,
  output logic [LW-1:0]    match_len
);
  localparam logic [LW-1:0] IDLE = '0;
  localparam logic [LW-1:0] FULL = LW'(PAT_W);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [PAT_W-1:0] pat;
  logic [LW-1:0] bord, base, nxt;
  logic [PAT_W:0] sh, hist;
  logic live, acc;
  // longest j<=lim whose low j bits of h equal the pattern's top j bits
  function automatic logic [LW-1:0] longest(input logic [PAT_W-1:0] p, input logic [PAT_W:0] h, input int lim);
    logic [PAT_W:0] t, m;
    longest = '0;
    for (int j = 1; j <= PAT_W; j++) begin
      t = {1'b0, p} >> (PAT_W - j);
      m = ~({(PAT_W+1){1'b1}} << j);
      if (j <= lim && ((h ^ t) & m) == '0) longest = LW'(j);
    end
  endfunction
  always_comb begin
    bord = longest(pat, {1'b0, pat}, PAT_W - 1);
    base = (match_len == FULL) ? (overlap_en ? bord : IDLE) : match_len;
    sh = {1'b0, pat} >> (PAT_W - int'(base));
    hist = {sh[PAT_W-1:0], din};
    nxt = longest(pat, hist, int'(base) + 1);
    acc = live && din_valid && !pat_load && nxt == FULL;
  end
  // live is the release flop: logic runs from the second edge after reset deasserts
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      live <= 1'b0;
      pat <= PAT_INIT;
      match_len <= IDLE;
      dout <= 1'b0;
      match_count <= '0;
    end else begin
      live <= 1'b1;
      dout <= acc;
      if (live) begin
        if (pat_load) begin
          pat <= pat_in;
          match_len <= IDLE;
        end else if (din_valid) match_len <= nxt;
        match_count <= cnt_clr ? '0 : (acc && match_count != CMAX) ? match_count + 1'b1 : match_count;
      end
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: random and directed checks of seq_detect_param against a string-matching model.
module tb_seq_detect_param;
  logic clk = 0, reset = 0, din = 0, din_valid = 0, overlap_en = 0, pat_load = 0, cnt_clr = 0;
  logic [3:0] pat_in = 0;
  logic dout, dout2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [2:0] match_len, match_len2;
  int n_vec = 0, n_err = 0;
  bit q[$];
  logic [3:0] m_pat = 4'b1001;
  int m_len = 0, m_cnt = 0, m_cnt2 = 0;
  logic m_dout = 0, m_live = 0;

  seq_detect_param dut (.clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .dout(dout), .match_count(match_count), .match_len(match_len));
  seq_detect_param #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .dout(dout2), .match_count(match_count2), .match_len(match_len2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // longest suffix of the bits seen since the last cut that is a prefix of the pattern
  function automatic int model_len();
    int best = 0;
    for (int j = 1; j <= 4 && j <= q.size(); j++) begin
      bit ok = 1;
      for (int i = 0; i < j; i++) if (q[q.size() - j + i] != m_pat[3 - i]) ok = 0;
      if (ok) best = j;
    end
    return best;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".dout"}, 32'(dout), 32'(m_dout));
    check({tag, ".len"}, 32'(match_len), m_len);
    check({tag, ".cnt"}, 32'(match_count), m_cnt);
    check({tag, ".cnt2"}, 32'(match_count2), m_cnt2);
  endtask

  task automatic cyc(input logic v, input logic b, input logic ov, input logic ld, input logic [3:0] pi, input logic clr);
    bit acc = 0;
    din_valid = v; din = b; overlap_en = ov; pat_load = ld; pat_in = pi; cnt_clr = clr;
    @(posedge clk);
    if (!m_live) begin
      m_live = 1;
      m_dout = 0;
    end else begin
      if (ld) begin
        m_pat = pi;
        q.delete();
        m_len = 0;
      end else if (v) begin
        if (m_len == 4 && !ov) q.delete();
        q.push_back(b);
        if (q.size() > 4) void'(q.pop_front());
        m_len = model_len();
        acc = (m_len == 4);
      end
      m_dout = acc;
      if (clr) begin
        m_cnt = 0;
        m_cnt2 = 0;
      end else if (acc) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    #1;
    check_all("cyc");
  endtask

  task automatic send(input logic [15:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) cyc(1, bits[i], ov, 0, 0, 0);
  endtask

  task automatic load(input logic [3:0] p);
    cyc(0, 0, 1, 1, p, 0);
  endtask

  task automatic async_reset();
    #2 reset = 0;
    #1;
    m_pat = 4'b1001; q.delete(); m_len = 0; m_dout = 0; m_cnt = 0; m_cnt2 = 0; m_live = 0;
    check_all("rst");
    #3 reset = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_all("por");
    #3 reset = 1;
    cyc(1, 1, 1, 0, 0, 0);
    send(16'b1001001, 7, 1);
    check("ov_count", 32'(match_count), 2);
    cyc(0, 0, 1, 0, 0, 1);
    load(4'b1001);
    send(16'b1001001, 7, 0);
    check("nov_count", 32'(match_count), 1);
    load(4'b1101);
    send(16'b1101101, 7, 1);
    send(16'b1100, 4, 1);
    load(4'b1001);
    send(16'b100, 3, 1);
    repeat (5) cyc(0, 0, 1, 0, 0, 0);
    send(16'b1, 1, 1);
    send(16'b1001001001001001, 16, 1);
    check("sat_count2", 32'(match_count2), 3);
    send(16'b100, 3, 1);
    cyc(1, 1, 1, 0, 0, 1);
    check("clr_dout", 32'(dout), 1);
    load(4'b1111);
    send(16'b111111, 6, 1);
    load(4'b1001);
    send(16'b100, 3, 1);
    check("pre_rst_len", 32'(match_len), 3);
    async_reset();
    cyc(0, 0, 1, 0, 0, 0);
    send(16'b1, 1, 1);
    for (int i = 0; i < 600; i++) begin
      logic ld = ($urandom_range(0, 39) == 0);
      logic [3:0] p = 4'($urandom_range(0, 15));
      if (ld && p[3] == p[0] && $urandom_range(0, 1) == 0) p = 4'b1111;
      if (i == 300) async_reset();
      overlap_en = ($urandom_range(0, 15) == 0) ? ~overlap_en : overlap_en;
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), overlap_en, ld, p, $urandom_range(0, 49) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
